pipeline_control_unit: RTL and testbench

- Parametrised successor to the pipeline decoder.
- Decodes the ID-stage instruction once into a control word and carries it through its own ID/EX, EX/MEM and MEM/WB control registers.
- Adds what the combinational decoder lacks: load-use/RAW hazard detection with stall, branch flush, and EX-stage forwarding selects.
- Sits beside the datapath pipeline registers. The datapath obeys stall/flush; this block applies them to its own control registers.

---
 rtl/pipeline_control_unit_pkg.sv | 107 ++++++++++
 rtl/pipeline_control_unit_inst_decoder.sv | 63 ++++++
 rtl/pipeline_control_unit.sv | 87 ++++++++
 tb/tb_pipeline_control_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_control_unit_pkg.sv
// Shared encodings, control-word layout and small helpers for the
// pipeline control unit and its instruction decoder.
package pipeline_control_unit_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_BEQ     = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLL = 6'h00;

  localparam logic [5:0] ALU_ADD = 6'd1;
  localparam logic [5:0] ALU_SUB = 6'd2;
  localparam logic [5:0] ALU_AND = 6'd3;
  localparam logic [5:0] ALU_OR  = 6'd4;
  localparam logic [5:0] ALU_NOR = 6'd5;
  localparam logic [5:0] ALU_SLL = 6'd6;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic [5:0] alu_op;
    logic       use_imm;
    logic       shift;
    logic       can_overflow;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic ctrl_t r_word(
    input logic [5:0]  alu,
    input logic        ovf,
    input logic [31:0] inst
  );
    ctrl_t c;
    c = CTRL_NOP;
    c.alu_op       = alu;
    c.can_overflow = ovf;
    c.shift        = (alu == ALU_SLL);
    c.reg_write    = 1'b1;
    c.dest         = inst[15:11];
    c.uses_rs      = !c.shift;
    c.rs           = c.shift ? 5'd0 : inst[25:21];
    c.uses_rt      = 1'b1;
    c.rt           = inst[20:16];
    return c;
  endfunction

  function automatic ctrl_t i_word(
    input logic [5:0]  alu,
    input logic        ovf,
    input logic [31:0] inst
  );
    ctrl_t c;
    c = CTRL_NOP;
    c.alu_op       = alu;
    c.can_overflow = ovf;
    c.use_imm      = 1'b1;
    c.reg_write    = 1'b1;
    c.dest         = inst[20:16];
    c.uses_rs      = 1'b1;
    c.rs           = inst[25:21];
    return c;
  endfunction

  // $0 is hardwired, so a zero destination never creates a dependency.
  function automatic logic dep_hit(input ctrl_t src, input ctrl_t id);
    return (src.dest != 5'd0) &&
           ((id.uses_rs && id.rs == src.dest) ||
            (id.uses_rt && id.rt == src.dest));
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input ctrl_t      exm,
    input ctrl_t      mwb
  );
    if (src == 5'd0)
      return FWD_RF;
    if (exm.reg_write && !exm.mem_read && exm.dest == src)
      return FWD_EXMEM;
    if (mwb.reg_write && mwb.dest == src)
      return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_control_unit_inst_decoder.sv
// Combinational decode of one instruction into a control word,
// immediate extension mode and illegal flag.
module inst_decoder
  import pipeline_control_unit_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        sign_extend,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       sp;

  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign sp = (op == OP_SPECIAL);
  assign sign_extend = !(op == OP_ANDI || op == OP_ORI);

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    // The all-zero word is the canonical bubble, not a real SLL.
    if (inst != '0) begin
      unique case (1'b1)
        sp && fn == FN_ADD: ctrl = r_word(ALU_ADD, 1'b1, inst);
        sp && fn == FN_SUB: ctrl = r_word(ALU_SUB, 1'b1, inst);
        sp && fn == FN_AND: ctrl = r_word(ALU_AND, 1'b0, inst);
        sp && fn == FN_OR:  ctrl = r_word(ALU_OR, 1'b0, inst);
        sp && fn == FN_NOR: ctrl = r_word(ALU_NOR, 1'b0, inst);
        sp && fn == FN_SLL: ctrl = r_word(ALU_SLL, 1'b0, inst);
        op == OP_ADDI: ctrl = i_word(ALU_ADD, 1'b1, inst);
        op == OP_ANDI: ctrl = i_word(ALU_AND, 1'b0, inst);
        op == OP_ORI:  ctrl = i_word(ALU_OR, 1'b0, inst);
        op == OP_LW: begin
          ctrl            = i_word(ALU_ADD, 1'b0, inst);
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        op == OP_SW: begin
          ctrl           = i_word(ALU_ADD, 1'b0, inst);
          ctrl.reg_write = 1'b0;
          ctrl.dest      = 5'd0;
          ctrl.mem_write = 1'b1;
          ctrl.uses_rt   = 1'b1;
          ctrl.rt        = inst[20:16];
        end
        op == OP_BEQ: begin
          ctrl           = i_word(ALU_SUB, 1'b0, inst);
          ctrl.use_imm   = 1'b0;
          ctrl.reg_write = 1'b0;
          ctrl.dest      = 5'd0;
          ctrl.branch    = 1'b1;
          ctrl.uses_rt   = 1'b1;
          ctrl.rt        = inst[20:16];
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Control pipeline beside the datapath: ID/EX, EX/MEM, MEM/WB control
// registers plus hazard stall, branch flush and EX forwarding selects.
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int ALUOP_W      = 6,
  parameter int REG_ADDR_W   = 5,
  parameter int BRANCH_STAGE = 3,
  parameter int FORWARD_EN   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           id_inst,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic                  id_sign_extend,
  output logic                  id_illegal,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic                  ex_use_imm,
  output logic                  ex_shift,
  output logic                  ex_can_overflow,
  output logic [1:0]            ex_fwd_a,
  output logic [1:0]            ex_fwd_b,
  output logic                  mem_write,
  output logic                  mem_branch,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_dest
);

  ctrl_t id_c;
  ctrl_t id_ex;
  ctrl_t ex_mem;
  ctrl_t mem_wb;
  logic  raw_load;
  logic  raw_alu;
  logic  unused_ok;

  inst_decoder u_dec (
    .inst        (id_inst),
    .ctrl        (id_c),
    .sign_extend (id_sign_extend),
    .illegal     (id_illegal)
  );

  assign raw_load = id_ex.mem_read && dep_hit(id_ex, id_c);

  // Without forwarding, any producer still in EX or MEM blocks ID.
  assign raw_alu = (FORWARD_EN == 0) &&
                   ((id_ex.reg_write && dep_hit(id_ex, id_c)) ||
                    (ex_mem.reg_write && dep_hit(ex_mem, id_c)));

  assign mem_branch = (BRANCH_STAGE == 2) ? id_ex.branch
                                          : ex_mem.branch;
  assign flush = mem_branch & branch_taken;
  assign stall = (raw_load | raw_alu) & ~flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_ex  <= CTRL_NOP;
      ex_mem <= CTRL_NOP;
      mem_wb <= CTRL_NOP;
    end else begin
      mem_wb <= ex_mem;
      ex_mem <= (flush && BRANCH_STAGE == 3) ? CTRL_NOP : id_ex;
      id_ex  <= (flush || stall) ? CTRL_NOP : id_c;
    end
  end

  assign ex_fwd_a = (FORWARD_EN != 0) ? fwd_sel(id_ex.rs, ex_mem, mem_wb)
                                      : FWD_RF;
  assign ex_fwd_b = (FORWARD_EN != 0) ? fwd_sel(id_ex.rt, ex_mem, mem_wb)
                                      : FWD_RF;

  assign ex_alu_op       = ALUOP_W'(id_ex.alu_op);
  assign ex_use_imm      = id_ex.use_imm;
  assign ex_shift        = id_ex.shift;
  assign ex_can_overflow = id_ex.can_overflow;
  assign mem_write       = ex_mem.mem_write;
  assign wb_reg_write    = mem_wb.reg_write;
  assign wb_mem_to_reg   = mem_wb.mem_to_reg;
  assign wb_dest         = REG_ADDR_W'(mem_wb.dest);

  assign unused_ok = ^{mem_wb, ex_mem, id_ex};

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench: one DUT with forwarding, one without, shared stimulus.
module tb_pipeline_control_unit;
  import pipeline_control_unit_pkg::*;

  logic        clock;
  logic        reset;
  logic [31:0] id_inst;
  logic        branch_taken;

  logic       stall_f1, flush_f1, sext_f1, ill_f1;
  logic [5:0] alu_f1;
  logic       imm_f1, shift_f1, ovf_f1;
  logic [1:0] fa_f1, fb_f1;
  logic       mw_f1, mb_f1, wrw_f1, wm2r_f1;
  logic [4:0] wd_f1;

  logic       stall_f0, flush_f0, sext_f0, ill_f0;
  logic [5:0] alu_f0;
  logic       imm_f0, shift_f0, ovf_f0;
  logic [1:0] fa_f0, fb_f0;
  logic       mw_f0, mb_f0, wrw_f0, wm2r_f0;
  logic [4:0] wd_f0;

  logic [24:0] outs_f1, outs_f0;
  int checks = 0;
  int errors = 0;

  assign outs_f1 = {stall_f1, flush_f1, ill_f1, alu_f1, imm_f1, shift_f1,
                    ovf_f1, fa_f1, fb_f1, mw_f1, mb_f1, wrw_f1, wm2r_f1,
                    wd_f1};
  assign outs_f0 = {stall_f0, flush_f0, ill_f0, alu_f0, imm_f0, shift_f0,
                    ovf_f0, fa_f0, fb_f0, mw_f0, mb_f0, wrw_f0, wm2r_f0,
                    wd_f0};

  pipeline_control_unit #(.FORWARD_EN(1), .BRANCH_STAGE(3)) u_f1 (
    .clock(clock), .reset(reset), .id_inst(id_inst),
    .branch_taken(branch_taken), .stall(stall_f1), .flush(flush_f1),
    .id_sign_extend(sext_f1), .id_illegal(ill_f1), .ex_alu_op(alu_f1),
    .ex_use_imm(imm_f1), .ex_shift(shift_f1), .ex_can_overflow(ovf_f1),
    .ex_fwd_a(fa_f1), .ex_fwd_b(fb_f1), .mem_write(mw_f1),
    .mem_branch(mb_f1), .wb_reg_write(wrw_f1), .wb_mem_to_reg(wm2r_f1),
    .wb_dest(wd_f1)
  );

  pipeline_control_unit #(.FORWARD_EN(0), .BRANCH_STAGE(3)) u_f0 (
    .clock(clock), .reset(reset), .id_inst(id_inst),
    .branch_taken(branch_taken), .stall(stall_f0), .flush(flush_f0),
    .id_sign_extend(sext_f0), .id_illegal(ill_f0), .ex_alu_op(alu_f0),
    .ex_use_imm(imm_f0), .ex_shift(shift_f0), .ex_can_overflow(ovf_f0),
    .ex_fwd_a(fa_f0), .ex_fwd_b(fb_f0), .mem_write(mw_f0),
    .mem_branch(mb_f0), .wb_reg_write(wrw_f0), .wb_mem_to_reg(wm2r_f0),
    .wb_dest(wd_f0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] r_(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh,
                                     input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick(input logic [31:0] inst);
    @(negedge clock);
    id_inst = inst;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    id_inst = '0;
    branch_taken = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    id_inst = '0;
    branch_taken = 1'b0;
    @(negedge clock);
    #1;
    checks++; if (outs_f1 !== 25'd0) begin errors++; $display("FAIL rst_hold_f1: got %h want 0", outs_f1); end
    checks++; if (outs_f0 !== 25'd0) begin errors++; $display("FAIL rst_hold_f0: got %h want 0", outs_f0); end
    reset = 1'b1;
    repeat (3) tick(32'h0);
    checks++; if (outs_f1 !== 25'd0) begin errors++; $display("FAIL rst_nop_f1: got %h want 0", outs_f1); end
    checks++; if (outs_f0 !== 25'd0) begin errors++; $display("FAIL rst_nop_f0: got %h want 0", outs_f0); end
    tick(r_(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
    tick(i_(6'h23, 5'd1, 5'd2, 16'd0));
    tick(r_(5'd2, 5'd4, 5'd3, 5'd0, 6'h20));
    checks++; if (stall_f1 !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %b want 1", stall_f1); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (outs_f1 !== 25'd0) begin errors++; $display("FAIL rst_async_f1: got %h want 0", outs_f1); end
    checks++; if (outs_f0 !== 25'd0) begin errors++; $display("FAIL rst_async_f0: got %h want 0", outs_f0); end
  endtask

  task automatic test_load_use();
    do_reset();
    tick(i_(6'h23, 5'd1, 5'd2, 16'd0));
    checks++; if (stall_f1 !== 1'b0) begin errors++; $display("FAIL lu_c0_stall: got %b want 0", stall_f1); end
    tick(r_(5'd2, 5'd4, 5'd3, 5'd0, 6'h20));
    checks++; if (stall_f1 !== 1'b1) begin errors++; $display("FAIL lu_c1_stall: got %b want 1", stall_f1); end
    checks++; if ({alu_f1, imm_f1} !== {ALU_ADD, 1'b1}) begin errors++; $display("FAIL lu_c1_ex: got %h want %h", {alu_f1, imm_f1}, {ALU_ADD, 1'b1}); end
    tick(r_(5'd2, 5'd4, 5'd3, 5'd0, 6'h20));
    checks++; if (stall_f1 !== 1'b0) begin errors++; $display("FAIL lu_c2_stall: got %b want 0", stall_f1); end
    checks++; if (alu_f1 !== 6'd0) begin errors++; $display("FAIL lu_c2_bubble: got %h want 0", alu_f1); end
    tick(32'h0);
    checks++; if (fa_f1 !== 2'b10) begin errors++; $display("FAIL lu_c3_fwd_a: got %b want 10", fa_f1); end
    checks++; if (fb_f1 !== 2'b00) begin errors++; $display("FAIL lu_c3_fwd_b: got %b want 00", fb_f1); end
    checks++; if ({wrw_f1, wm2r_f1, wd_f1} !== {1'b1, 1'b1, 5'd2}) begin errors++; $display("FAIL lu_c3_wb: got %h want %h", {wrw_f1, wm2r_f1, wd_f1}, {1'b1, 1'b1, 5'd2}); end
  endtask

  task automatic test_forward();
    do_reset();
    tick(r_(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
    tick(r_(5'd3, 5'd3, 5'd5, 5'd0, 6'h22));
    checks++; if (stall_f1 !== 1'b0) begin errors++; $display("FAIL fw_c1_stall: got %b want 0", stall_f1); end
    checks++; if ({alu_f1, ovf_f1} !== {ALU_ADD, 1'b1}) begin errors++; $display("FAIL fw_c1_alu: got %h want %h", {alu_f1, ovf_f1}, {ALU_ADD, 1'b1}); end
    tick(32'h0);
    checks++; if ({fa_f1, fb_f1} !== 4'b0101) begin errors++; $display("FAIL fw_c2_sel: got %b want 0101", {fa_f1, fb_f1}); end
    checks++; if (alu_f1 !== ALU_SUB) begin errors++; $display("FAIL fw_c2_alu: got %h want %h", alu_f1, ALU_SUB); end
    tick(32'h0);
    checks++; if ({wrw_f1, wd_f1} !== {1'b1, 5'd3}) begin errors++; $display("FAIL fw_c3_wb: got %h want %h", {wrw_f1, wd_f1}, {1'b1, 5'd3}); end
    tick(32'h0);
    checks++; if (wd_f1 !== 5'd5) begin errors++; $display("FAIL fw_c4_wb: got %0d want 5", wd_f1); end
  endtask

  task automatic test_no_forward();
    do_reset();
    tick(r_(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
    tick(r_(5'd3, 5'd3, 5'd5, 5'd0, 6'h22));
    checks++; if (stall_f0 !== 1'b1) begin errors++; $display("FAIL nf_c1_stall: got %b want 1", stall_f0); end
    tick(r_(5'd3, 5'd3, 5'd5, 5'd0, 6'h22));
    checks++; if (stall_f0 !== 1'b1) begin errors++; $display("FAIL nf_c2_stall: got %b want 1", stall_f0); end
    checks++; if (alu_f0 !== 6'd0) begin errors++; $display("FAIL nf_c2_bubble: got %h want 0", alu_f0); end
    tick(r_(5'd3, 5'd3, 5'd5, 5'd0, 6'h22));
    checks++; if (stall_f0 !== 1'b0) begin errors++; $display("FAIL nf_c3_stall: got %b want 0", stall_f0); end
    checks++; if (wd_f0 !== 5'd3) begin errors++; $display("FAIL nf_c3_wb: got %0d want 3", wd_f0); end
    tick(32'h0);
    checks++; if (alu_f0 !== ALU_SUB) begin errors++; $display("FAIL nf_c4_alu: got %h want %h", alu_f0, ALU_SUB); end
    checks++; if ({fa_f0, fb_f0} !== 4'b0000) begin errors++; $display("FAIL nf_c4_sel: got %b want 0000", {fa_f0, fb_f0}); end
  endtask

  task automatic test_flush();
    do_reset();
    tick(i_(6'h04, 5'd1, 5'd2, 16'd8));
    tick(r_(5'd1, 5'd2, 5'd6, 5'd0, 6'h20));
    tick(i_(6'h0D, 5'd1, 5'd7, 16'd5));
    branch_taken = 1'b1;
    #1;
    checks++; if ({mb_f1, flush_f1, stall_f1} !== 3'b110) begin errors++; $display("FAIL fl_c2: got %b want 110", {mb_f1, flush_f1, stall_f1}); end
    tick(32'h0);
    branch_taken = 1'b0;
    #1;
    checks++; if ({flush_f1, alu_f1} !== 7'd0) begin errors++; $display("FAIL fl_c3: got %h want 0", {flush_f1, alu_f1}); end
    tick(32'h0);
    checks++; if (wrw_f1 !== 1'b0) begin errors++; $display("FAIL fl_c4_wb: got %b want 0", wrw_f1); end
    tick(32'h0);
    checks++; if (wrw_f1 !== 1'b0) begin errors++; $display("FAIL fl_c5_wb: got %b want 0", wrw_f1); end
    tick(i_(6'h04, 5'd1, 5'd2, 16'd8));
    tick(i_(6'h23, 5'd1, 5'd2, 16'd0));
    tick(r_(5'd2, 5'd4, 5'd3, 5'd0, 6'h20));
    branch_taken = 1'b1;
    #1;
    checks++; if ({flush_f1, stall_f1} !== 2'b10) begin errors++; $display("FAIL fl_lu_prio: got %b want 10", {flush_f1, stall_f1}); end
    tick(32'h0);
    branch_taken = 1'b0;
    #1;
    checks++; if (alu_f1 !== 6'd0) begin errors++; $display("FAIL fl_lu_c3: got %h want 0", alu_f1); end
    tick(32'h0);
    checks++; if ({wrw_f1, wm2r_f1} !== 2'b00) begin errors++; $display("FAIL fl_lu_c4_wb: got %b want 00", {wrw_f1, wm2r_f1}); end
  endtask

  task automatic test_zero_illegal();
    do_reset();
    tick(r_(5'd1, 5'd2, 5'd0, 5'd0, 6'h20));
    tick(r_(5'd0, 5'd0, 5'd4, 5'd0, 6'h25));
    checks++; if ({stall_f1, stall_f0} !== 2'b00) begin errors++; $display("FAIL z_stall: got %b want 00", {stall_f1, stall_f0}); end
    tick(32'hFC00_0000);
    checks++; if (ill_f1 !== 1'b1) begin errors++; $display("FAIL z_illegal: got %b want 1", ill_f1); end
    checks++; if ({fa_f1, fb_f1} !== 4'b0000) begin errors++; $display("FAIL z_fwd: got %b want 0000", {fa_f1, fb_f1}); end
    checks++; if (alu_f1 !== ALU_OR) begin errors++; $display("FAIL z_alu_or: got %h want %h", alu_f1, ALU_OR); end
    tick(32'h0);
    checks++; if ({ill_f1, alu_f1, imm_f1, shift_f1, ovf_f1} !== 10'd0) begin errors++; $display("FAIL z_ill_ex: got %h want 0", {ill_f1, alu_f1, imm_f1, shift_f1, ovf_f1}); end
    tick(32'h0);
    checks++; if ({mw_f1, wrw_f1, wd_f1} !== {1'b0, 1'b1, 5'd4}) begin errors++; $display("FAIL z_c4: got %h want %h", {mw_f1, wrw_f1, wd_f1}, {1'b0, 1'b1, 5'd4}); end
    tick(32'h0);
    checks++; if (wrw_f1 !== 1'b0) begin errors++; $display("FAIL z_ill_wb: got %b want 0", wrw_f1); end
  endtask

  task automatic test_decode();
    do_reset();
    tick(i_(6'h08, 5'd1, 5'd5, 16'hFFFF));
    checks++; if ({sext_f1, ill_f1} !== 2'b10) begin errors++; $display("FAIL dc_addi_id: got %b want 10", {sext_f1, ill_f1}); end
    tick(i_(6'h2B, 5'd1, 5'd5, 16'd4));
    checks++; if ({alu_f1, imm_f1, ovf_f1, stall_f1} !== {ALU_ADD, 3'b110}) begin errors++; $display("FAIL dc_addi_ex: got %h want %h", {alu_f1, imm_f1, ovf_f1, stall_f1}, {ALU_ADD, 3'b110}); end
    tick(i_(6'h0D, 5'd1, 5'd7, 16'd5));
    checks++; if (sext_f1 !== 1'b0) begin errors++; $display("FAIL dc_ori_sext: got %b want 0", sext_f1); end
    checks++; if ({fa_f1, fb_f1, imm_f1, ovf_f1} !== 6'b000110) begin errors++; $display("FAIL dc_sw_ex: got %b want 000110", {fa_f1, fb_f1, imm_f1, ovf_f1}); end
    tick(r_(5'd0, 5'd5, 5'd6, 5'd2, 6'h00));
    checks++; if (mw_f1 !== 1'b1) begin errors++; $display("FAIL dc_sw_mem: got %b want 1", mw_f1); end
    checks++; if ({alu_f1, imm_f1, ovf_f1} !== {ALU_OR, 2'b10}) begin errors++; $display("FAIL dc_ori_ex: got %h want %h", {alu_f1, imm_f1, ovf_f1}, {ALU_OR, 2'b10}); end
    checks++; if ({wrw_f1, wm2r_f1, wd_f1} !== {2'b10, 5'd5}) begin errors++; $display("FAIL dc_addi_wb: got %h want %h", {wrw_f1, wm2r_f1, wd_f1}, {2'b10, 5'd5}); end
    tick(32'h0);
    checks++; if ({alu_f1, shift_f1, fa_f1, fb_f1, mw_f1} !== {ALU_SLL, 6'b100000}) begin errors++; $display("FAIL dc_sll_ex: got %h want %h", {alu_f1, shift_f1, fa_f1, fb_f1, mw_f1}, {ALU_SLL, 6'b100000}); end
  endtask

  initial begin
    reset = 1'b0;
    id_inst = '0;
    branch_taken = 1'b0;
    test_reset();
    test_load_use();
    test_forward();
    test_no_forward();
    test_flush();
    test_zero_illegal();
    test_decode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
